// File: rtl/tcdm_prio_scheduler_if.sv
// Memory-side view of the TCDM core and HWPE branch handshakes watched by the priority scheduler.
interface tcdm_prio_scheduler_if #(
  parameter int NB_CORES = 8
) ();
  logic [NB_CORES-1:0] core_req;
  logic [NB_CORES-1:0] core_gnt;
  logic                hwpe_req;
  logic                hwpe_gnt;

  modport master (
    output core_req,
    output core_gnt,
    output hwpe_req,
    output hwpe_gnt
  );

  modport slave (
    input core_req,
    input core_gnt,
    input hwpe_req,
    input hwpe_gnt
  );
endinterface

// File: rtl/tcdm_prio_scheduler.sv
// TCDM branch priority scheduler: fixed, starvation-toggle and time-slice policies.
// Optional stall statistics counters are built only when TCDM_SCHED_STATS_EN is defined.
module tcdm_prio_scheduler #(
  parameter int NB_CORES    = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic [CNT_WIDTH-1:0]   max_stall_i,
  input  logic [SLICE_WIDTH-1:0] slice_len_i,
  tcdm_prio_scheduler_if.slave   tcdm,
  output logic                   hwpe_prio_o,
  output logic                   starve_event_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o,
  input  logic                   clear_stats_i,
  output logic [31:0]            core_stall_cycles_o,
  output logic [31:0]            hwpe_stall_cycles_o
);

  typedef enum logic {
    CORE_HI = 1'b0,
    HWPE_HI = 1'b1
  } prio_e;

  localparam logic [1:0] MODE_CORE  = 2'd0;
  localparam logic [1:0] MODE_HWPE  = 2'd1;
  localparam logic [1:0] MODE_STARV = 2'd2;
  localparam logic [1:0] MODE_SLICE = 2'd3;

  prio_e                  r_prio;
  prio_e                  w_prio_next;
  prio_e                  w_prio_flip;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;
  logic [CNT_WIDTH-1:0]   w_stall_next;
  logic [SLICE_WIDTH-1:0] r_slice_cnt;
  logic [SLICE_WIDTH-1:0] w_slice_next;
  logic [1:0]             r_mode;
  logic                   r_starve;
  logic                   w_starve_next;

  logic [NB_CORES-1:0]    w_core_pend;
  logic                   w_core_stalled;
  logic                   w_hwpe_stalled;
  logic                   w_low_stalled;
  logic                   w_mode_chg;
  logic [CNT_WIDTH-1:0]   w_stall_thr;
  logic [SLICE_WIDTH-1:0] w_slice_thr;

  assign w_core_pend    = tcdm.core_req & ~tcdm.core_gnt;
  assign w_core_stalled = |w_core_pend;
  assign w_hwpe_stalled = tcdm.hwpe_req & ~tcdm.hwpe_gnt;
  // Only the side currently losing conflicts can starve.
  assign w_low_stalled  = (r_prio == HWPE_HI) ? w_core_stalled : w_hwpe_stalled;
  assign w_mode_chg     = (mode_i != r_mode);
  assign w_prio_flip    = (r_prio == CORE_HI) ? HWPE_HI : CORE_HI;

  // Thresholds compared with >= so a shrunk limit fires on the next compare.
  assign w_stall_thr = max_stall_i - CNT_WIDTH'(1);
  assign w_slice_thr = (slice_len_i == '0) ? '0 : (slice_len_i - SLICE_WIDTH'(1));

  always_comb begin
    w_prio_next   = r_prio;
    w_stall_next  = '0;
    w_slice_next  = '0;
    w_starve_next = 1'b0;
    if (!enable_i) begin
      w_prio_next = CORE_HI;
    end else if (w_mode_chg) begin
      w_prio_next = (mode_i == MODE_HWPE) ? HWPE_HI : CORE_HI;
    end else begin
      case (mode_i)
        MODE_CORE: w_prio_next = CORE_HI;
        MODE_HWPE: w_prio_next = HWPE_HI;
        MODE_STARV: begin
          if ((max_stall_i != '0) && w_low_stalled) begin
            if (r_stall_cnt >= w_stall_thr) begin
              w_prio_next   = w_prio_flip;
              w_starve_next = 1'b1;
            end else begin
              w_stall_next = r_stall_cnt + CNT_WIDTH'(1);
            end
          end
        end
        MODE_SLICE: begin
          if (r_slice_cnt >= w_slice_thr) begin
            w_prio_next = w_prio_flip;
          end else begin
            w_slice_next = r_slice_cnt + SLICE_WIDTH'(1);
          end
        end
        default: w_prio_next = CORE_HI;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio      <= CORE_HI;
      r_stall_cnt <= '0;
      r_slice_cnt <= '0;
      r_mode      <= MODE_CORE;
      r_starve    <= 1'b0;
    end else begin
      r_prio      <= w_prio_next;
      r_stall_cnt <= w_stall_next;
      r_slice_cnt <= w_slice_next;
      r_mode      <= mode_i;
      r_starve    <= w_starve_next;
    end
  end

  assign hwpe_prio_o    = (r_prio == HWPE_HI);
  assign starve_event_o = r_starve;
  assign stall_cnt_o    = r_stall_cnt;

`ifdef TCDM_SCHED_STATS_EN
  logic [31:0] r_core_stall_cycles;
  logic [31:0] r_hwpe_stall_cycles;

  // Saturating counters; clear beats a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_stats_i) begin
      r_core_stall_cycles <= '0;
      r_hwpe_stall_cycles <= '0;
    end else begin
      if (w_core_stalled && (r_core_stall_cycles != 32'hFFFF_FFFF)) begin
        r_core_stall_cycles <= r_core_stall_cycles + 32'd1;
      end
      if (w_hwpe_stalled && (r_hwpe_stall_cycles != 32'hFFFF_FFFF)) begin
        r_hwpe_stall_cycles <= r_hwpe_stall_cycles + 32'd1;
      end
    end
  end

  assign core_stall_cycles_o = r_core_stall_cycles;
  assign hwpe_stall_cycles_o = r_hwpe_stall_cycles;
`else
  logic w_unused_clear_stats;
  assign w_unused_clear_stats = clear_stats_i;
  assign core_stall_cycles_o  = '0;
  assign hwpe_stall_cycles_o  = '0;
`endif

endmodule
